// File: rtl/moving_sum_filter_if.sv
// Sample/result bundle between the delay line front end and the moving-sum filter.
// The master side drives samples in; the slave side (the filter) returns sum, average and peak.
interface moving_sum_filter_if #(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned WDEPTH    = 5,
    parameter int unsigned SSIZE     = DSIZE + $clog2(WDEPTH + 1),
    parameter int unsigned AVG_SHIFT = 2
);
    logic                       Clr;
    logic                       Sample_en;
    logic [DSIZE-1:0]           Din;
    logic [DSIZE-1:0]           Dly;
    logic [SSIZE-1:0]           Sum;
    logic [SSIZE-AVG_SHIFT-1:0] Avg;
    logic                       Sum_valid;
    logic                       Primed;
    logic [SSIZE-1:0]           Peak;

    modport master (
        output Clr, Sample_en, Din, Dly,
        input  Sum, Avg, Sum_valid, Primed, Peak
    );

    modport slave (
        input  Clr, Sample_en, Din, Dly,
        output Sum, Avg, Sum_valid, Primed, Peak
    );
endinterface

// File: rtl/moving_sum_filter.sv
// Running boxcar sum over the last WDEPTH samples with shifted average and peak hold.
// Define MOVSUM_ROUND_EN to round Avg half-up instead of truncating.
module moving_sum_filter #(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned WDEPTH    = 5,
    parameter int unsigned SSIZE     = DSIZE + $clog2(WDEPTH + 1),
    parameter int unsigned AVG_SHIFT = 2
) (
    input logic                 Clock,
    input logic                 Reset,
    moving_sum_filter_if.slave  bus
);
    localparam int unsigned FillW = $clog2(WDEPTH + 1);
    localparam int unsigned AvgW  = SSIZE - AVG_SHIFT;
    localparam logic [FillW-1:0] FillMax = FillW'(WDEPTH);
`ifdef MOVSUM_ROUND_EN
    localparam logic [SSIZE:0] RoundInc =
        (AVG_SHIFT == 0) ? '0 : ((SSIZE + 1)'(1) << (AVG_SHIFT - 1));
`endif

    logic [SSIZE-1:0] acc_q, acc_d;
    logic [FillW-1:0] fill_q, fill_d;
    logic             primed_q, primed_d;
    logic             sum_valid_q, sum_valid_d;
    logic [SSIZE-1:0] peak_q, peak_d;
    logic [AvgW-1:0]  avg_q, avg_d;

    always_comb begin
        acc_d       = acc_q;
        fill_d      = fill_q;
        primed_d    = primed_q;
        sum_valid_d = 1'b0;
        peak_d      = peak_q;
        avg_d       = avg_q;
        if (bus.Clr) begin
            acc_d    = '0;
            fill_d   = '0;
            primed_d = 1'b0;
            peak_d   = '0;
            avg_d    = '0;
        end else if (bus.Sample_en) begin
            // Dly is stale until the window is full, so it is only retired once primed.
            acc_d = SSIZE'({1'b0, acc_q} + (SSIZE + 1)'(bus.Din)
                           - (primed_q ? (SSIZE + 1)'(bus.Dly) : '0));
            if (fill_q != FillMax) begin
                fill_d = fill_q + FillW'(1);
            end
            primed_d    = (fill_d == FillMax);
            sum_valid_d = primed_d;
            if (sum_valid_d && (acc_d > peak_q)) begin
                peak_d = acc_d;
            end
`ifdef MOVSUM_ROUND_EN
            avg_d = AvgW'(({1'b0, acc_d} + RoundInc) >> AVG_SHIFT);
`else
            avg_d = AvgW'(acc_d >> AVG_SHIFT);
`endif
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc_q       <= '0;
            fill_q      <= '0;
            primed_q    <= 1'b0;
            sum_valid_q <= 1'b0;
            peak_q      <= '0;
            avg_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            primed_q    <= primed_d;
            sum_valid_q <= sum_valid_d;
            peak_q      <= peak_d;
            avg_q       <= avg_d;
        end
    end

    assign bus.Sum       = acc_q;
    assign bus.Avg       = avg_q;
    assign bus.Sum_valid = sum_valid_q;
    assign bus.Primed    = primed_q;
    assign bus.Peak      = peak_q;
endmodule

// File: tb/tb_moving_sum_filter.sv
// Scoreboard bench for moving_sum_filter: directed sample vectors push expected results,
// a negedge monitor pops and compares whenever Sum_valid is high.
module tb_moving_sum_filter;
    localparam int unsigned WDEPTH = 5;

    typedef struct {
        int sum;
        int avg;
        int peak;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   hist[$];
    logic [7:0] stale_dly = 8'hA5;

    localparam int RampSum [10] = '{0, 1, 3, 6, 10, 15, 20, 25, 30, 35};
    localparam int RampAvgT[10] = '{0, 0, 0, 0, 2, 3, 5, 6, 7, 8};
    localparam int RampAvgR[10] = '{0, 0, 0, 0, 3, 4, 5, 6, 8, 9};

    moving_sum_filter_if bus ();

    moving_sum_filter dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        if (!Reset && bus.Sum_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sum_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", int'(bus.Sum), e.sum);
                check("avg", int'(bus.Avg), e.avg);
                check("peak", int'(bus.Peak), e.peak);
                check("primed_on_valid", int'(bus.Primed), 1);
            end
        end
    end

    task automatic send(input int din, input bit vld, input int sum, input int avg_t,
                        input int avg_r, input int peak, input bit prm, input int gap);
        int   n;
        exp_t e;
        n = hist.size();
        bus.Din = 8'(din);
        bus.Dly = (n >= WDEPTH) ? 8'(hist[n - WDEPTH]) : stale_dly;
        hist.push_back(din);
        bus.Sample_en = 1'b1;
        if (vld) begin
            e.sum  = sum;
`ifdef MOVSUM_ROUND_EN
            e.avg  = avg_r;
`else
            e.avg  = avg_t;
`endif
            e.peak = peak;
            exp_q.push_back(e);
        end
        @(posedge Clock);
        #1;
        bus.Sample_en = 1'b0;
        repeat (gap) begin
            @(posedge Clock);
            #1;
        end
        check("sum_hold", int'(bus.Sum), sum);
        check("peak_hold", int'(bus.Peak), peak);
        check("primed", int'(bus.Primed), int'(prm));
    endtask

    task automatic do_clr(input bit with_en, input int din);
        bus.Clr       = 1'b1;
        bus.Sample_en = with_en;
        bus.Din       = 8'(din);
        bus.Dly       = stale_dly;
        @(posedge Clock);
        #1;
        bus.Clr       = 1'b0;
        bus.Sample_en = 1'b0;
        hist.delete();
        check("clr_sum", int'(bus.Sum), 0);
        check("clr_avg", int'(bus.Avg), 0);
        check("clr_peak", int'(bus.Peak), 0);
        check("clr_primed", int'(bus.Primed), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sum"}, int'(bus.Sum), 0);
        check({tag, "_avg"}, int'(bus.Avg), 0);
        check({tag, "_peak"}, int'(bus.Peak), 0);
        check({tag, "_primed"}, int'(bus.Primed), 0);
        check({tag, "_valid"}, int'(bus.Sum_valid), 0);
    endtask

    initial begin
        Reset         = 1'b1;
        bus.Clr       = 1'b0;
        bus.Sample_en = 1'b0;
        bus.Din       = '0;
        bus.Dly       = '0;
        repeat (2) @(posedge Clock);
        #1;
        check_zero("reset");
        Reset = 1'b0;
        @(posedge Clock);
        #1;

        // Ramp, back-to-back enables: fill then steady state.
        for (int i = 0; i < 10; i++) begin
            send(i, i >= 4, RampSum[i], RampAvgT[i], RampAvgR[i],
                 (i >= 4) ? RampSum[i] : 0, i >= 4, 0);
        end

        // Same ramp, enable every third cycle; outputs must hold in the gaps.
        do_clr(1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            send(i, i >= 4, RampSum[i], RampAvgT[i], RampAvgR[i],
                 (i >= 4) ? RampSum[i] : 0, i >= 4, 2);
        end

        // Peak hold: five samples of 200, then five of 10.
        do_clr(1'b0, 0);
        send(200, 0, 200, 0, 0, 0, 0, 0);
        send(200, 0, 400, 0, 0, 0, 0, 0);
        send(200, 0, 600, 0, 0, 0, 0, 0);
        send(200, 0, 800, 0, 0, 0, 0, 0);
        send(200, 1, 1000, 250, 250, 1000, 1, 0);
        send(10, 1, 810, 202, 203, 1000, 1, 0);
        send(10, 1, 620, 155, 155, 1000, 1, 1);
        send(10, 1, 430, 107, 108, 1000, 1, 0);
        send(10, 1, 240, 60, 60, 1000, 1, 0);
        send(10, 1, 50, 12, 13, 1000, 1, 0);

        // Clr wins over Sample_en; the 77 is dropped and a full refill is needed.
        do_clr(1'b1, 77);
        check("clr_no_valid", int'(bus.Sum_valid), 0);
        send(7, 0, 7, 0, 0, 0, 0, 0);
        send(7, 0, 14, 0, 0, 0, 0, 0);
        send(7, 0, 21, 0, 0, 0, 0, 0);
        send(7, 0, 28, 0, 0, 0, 0, 0);
        send(7, 1, 35, 8, 9, 35, 1, 0);

        // Async reset mid-window, between clock edges.
        do_clr(1'b0, 0);
        send(50, 0, 50, 0, 0, 0, 0, 0);
        send(50, 0, 100, 0, 0, 0, 0, 0);
        send(50, 0, 150, 0, 0, 0, 0, 0);
        #2;
        Reset = 1'b1;
        #1;
        check_zero("async_reset");
        #2;
        Reset = 1'b0;
        hist.delete();
        @(posedge Clock);
        #1;
        send(1, 0, 1, 0, 0, 0, 0, 0);
        send(2, 0, 3, 0, 0, 0, 0, 0);
        send(3, 0, 6, 0, 0, 0, 0, 0);
        send(4, 0, 10, 0, 0, 0, 0, 0);
        send(5, 1, 15, 3, 4, 15, 1, 0);

        // Full-scale input must not wrap the sum.
        do_clr(1'b0, 0);
        stale_dly = 8'hFF;
        send(255, 0, 255, 0, 0, 0, 0, 0);
        send(255, 0, 510, 0, 0, 0, 0, 0);
        send(255, 0, 765, 0, 0, 0, 0, 0);
        send(255, 0, 1020, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            send(255, 1, 1275, 318, 319, 1275, 1, 0);
        end

        repeat (3) @(posedge Clock);
        #1;
        check("pending_expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
